// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames one byte as start, 8 data bits LSB-first, optional parity
// and 1 or 2 stop bits. tx, tx_busy and tx_done are all driven straight from flops.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic             stop_cnt_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic             tx_r;
  logic             busy_r;
  logic             done_r;
  logic             baud_last_s;

  // Parity of the byte as it goes on the line: even = XOR of the bits, odd = its inverse.
  function automatic logic parity_bit(input logic [7:0] d);
    parity_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign baud_last_s = (baud_cnt_r == CNT_LAST);
  assign tx          = tx_r;
  assign tx_busy     = busy_r;
  assign tx_done     = done_r;

  // Frame sequencer: the baud counter restarts at every bit boundary so bits never drift.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (new_tx_data) begin
            shift_r    <= tx_data;
            par_r      <= parity_bit(tx_data);
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            tx_r       <= shift_r[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              stop_cnt_r <= 1'b0;
              if (PARITY != 0) begin
                tx_r    <= par_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              shift_r <= {1'b0, shift_r[7:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            state_r    <= ST_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            if (stop_cnt_r == STOP_LAST) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= '0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench: four transmitter configurations side by side, each compared every cycle
// against a frame-level model (bit index = cycles since acceptance / CLKS_PER_BIT).
module tb_uart_tx_serializer;

  localparam int C  = 4;
  localparam int ND = 4;
  localparam int PAR [ND] = '{0, 2, 1, 0};
  localparam int STB [ND] = '{1, 1, 1, 2};

  logic            clk;
  logic            resetn;
  logic [7:0]      tx_data;
  logic [ND-1:0]   new_tx_data;
  logic [ND-1:0]   busy_s;
  logic [ND-1:0]   done_s;
  logic [ND-1:0]   tx_s;

  int n_checks;
  int n_errors;

  // model state per configuration
  bit   m_active [ND];
  int   m_pos    [ND];
  bit   m_done   [ND];
  logic m_bits   [ND][0:15];
  int   m_frames [ND];
  int   d_frames [ND];
  int   busy_cnt [ND];
  bit   b2b_sent [ND];

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      uart_tx_serializer #(
        .CLKS_PER_BIT(C),
        .PARITY      (PAR[g]),
        .STOP_BITS   (STB[g])
      ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data[g]),
        .tx_busy    (busy_s[g]),
        .tx_done    (done_s[g]),
        .tx         (tx_s[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int frame_len(input int c);
    return C * (10 + ((PAR[c] != 0) ? 1 : 0) + (STB[c] - 1));
  endfunction

  task automatic model_step(input int c);
    logic [7:0] d;
    if (!resetn) begin
      m_active[c] = 1'b0;
      m_done[c]   = 1'b0;
      m_pos[c]    = 0;
    end else begin
      m_done[c] = 1'b0;
      if (m_active[c]) begin
        m_pos[c]++;
        if (m_pos[c] == frame_len(c)) begin
          m_active[c] = 1'b0;
          m_done[c]   = 1'b1;
          m_frames[c]++;
        end
      end else if (new_tx_data[c]) begin
        d = tx_data;
        for (int i = 0; i < 16; i++) m_bits[c][i] = 1'b1;
        m_bits[c][0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[c][1+i] = d[i];
        if (PAR[c] == 2) m_bits[c][9] = ^d;
        else if (PAR[c] == 1) m_bits[c][9] = ~(^d);
        m_active[c] = 1'b1;
        m_pos[c]    = 0;
      end
    end
  endtask

  task automatic tick();
    logic exp_tx;
    @(posedge clk);
    for (int c = 0; c < ND; c++) model_step(c);
    #1;
    for (int c = 0; c < ND; c++) begin
      exp_tx = m_active[c] ? m_bits[c][m_pos[c] / C] : 1'b1;
      check_val($sformatf("tx%0d", c),   {31'd0, tx_s[c]},   {31'd0, exp_tx});
      check_val($sformatf("busy%0d", c), {31'd0, busy_s[c]}, {31'd0, m_active[c]});
      check_val($sformatf("done%0d", c), {31'd0, done_s[c]}, {31'd0, m_done[c]});
      if (done_s[c] === 1'b1) d_frames[c]++;
      if (busy_s[c] === 1'b1) busy_cnt[c]++;
    end
  endtask

  task automatic send_all(input logic [7:0] d);
    tx_data     = d;
    new_tx_data = '1;
    tick();
    new_tx_data = '0;
  endtask

  task automatic frame_busy_check(input logic [7:0] d, input string tag);
    for (int c = 0; c < ND; c++) busy_cnt[c] = 0;
    send_all(d);
    repeat (50) tick();
    for (int c = 0; c < ND; c++)
      check_val($sformatf("%s_busy_len%0d", tag, c), busy_cnt[c], frame_len(c));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    resetn      = 1'b0;
    tx_data     = 8'h00;
    new_tx_data = '0;
    for (int c = 0; c < ND; c++) begin
      m_active[c] = 1'b0; m_pos[c] = 0; m_done[c] = 1'b0;
      m_frames[c] = 0; d_frames[c] = 0; busy_cnt[c] = 0; b2b_sent[c] = 1'b0;
      for (int i = 0; i < 16; i++) m_bits[c][i] = 1'b1;
    end

    // reset state, including a request that reset must override
    tick();
    new_tx_data = '1;
    tx_data     = 8'h77;
    tick();
    new_tx_data = '0;
    resetn      = 1'b1;
    repeat (2) tick();

    frame_busy_check(8'hA5, "a5");
    frame_busy_check(8'hFF, "ff");

    // request mid-frame is dropped; data changes mid-frame are ignored
    send_all(8'h11);
    repeat (9) tick();
    tx_data     = 8'h3C;
    new_tx_data = '1;
    tick();
    new_tx_data = '0;
    for (int i = 0; i < 50; i++) begin
      tx_data = 8'($urandom);
      tick();
    end

    // back-to-back: next request issued in each configuration's tx_done cycle
    send_all(8'h80);
    tx_data = 8'h01;
    for (int i = 0; i < 110; i++) begin
      for (int c = 0; c < ND; c++) begin
        new_tx_data[c] = m_done[c] && !b2b_sent[c];
        if (m_done[c]) b2b_sent[c] = 1'b1;
      end
      tick();
    end
    new_tx_data = '0;
    for (int c = 0; c < ND; c++)
      check_val($sformatf("b2b_issued%0d", c), {31'd0, b2b_sent[c]}, 32'd1);

    // randomized traffic with random request timing per configuration
    for (int i = 0; i < 600; i++) begin
      tx_data = 8'($urandom);
      for (int c = 0; c < ND; c++) new_tx_data[c] = ($urandom_range(0, 15) == 0);
      tick();
    end
    new_tx_data = '0;
    repeat (50) tick();

    // reset during data bit 3 aborts the frame without tx_done
    send_all(8'hC3);
    repeat (16) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    send_all(8'h5A);
    repeat (50) tick();

    for (int c = 0; c < ND; c++)
      check_val($sformatf("frames%0d", c), d_frames[c], m_frames[c]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
